// File: rtl/ro_uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ro_uart_tx_if                                                      |
// | Bundle between the K2 RO output register and the UART output stage |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface ro_uart_tx_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    logic [N-1:0]                 ro_in;
    logic                         tx;
    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   level;
    logic                         overflow;

    modport master (
        output ro_in,
        input  tx,
        input  busy,
        input  level,
        input  overflow
    );

    modport slave (
        input  ro_in,
        output tx,
        output busy,
        output level,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/ro_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ro_uart_tx                                                         |
// | Captures changes of K2.RO into a FIFO and sends them as 8N1 frames |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module ro_uart_tx #(
    parameter int N            = 8,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    ro_uart_tx_if.slave     bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [LW-1:0] c_full      = LW'(DEPTH);
    localparam logic [BW-1:0] c_baud_last = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_bit_last  = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_shift, w_shift_nxt;
    logic [BW-1:0]   r_baud,  w_baud_nxt;
    logic [CW-1:0]   r_bit,   w_bit_nxt;
    logic            r_tx,    w_tx_nxt;

    logic [N-1:0]    r_last_ro;
    logic [N-1:0]    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            r_overflow;

    logic            w_change;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_drop;
    logic            w_baud_end;
    logic            w_has_data;

    assign w_change   = (bus.ro_in != r_last_ro);
    assign w_has_data = (r_level != '0);
    assign w_baud_end = (r_baud == c_baud_last);
    // A full FIFO still accepts a push when the FSM frees a slot on the same edge.
    assign w_push_ok  = w_change && ((r_level != c_full) || w_pop);
    assign w_drop     = w_change && !w_push_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_has_data) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt  = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == c_bit_last) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_nxt  = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    // Chain straight into the next start bit when bytes are waiting.
                    if (w_has_data) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_tx_nxt = 1'b1;
        if (w_state_nxt == S_START) begin
            w_tx_nxt = 1'b0;
        end else if (w_state_nxt == S_DATA) begin
            w_tx_nxt = w_shift_nxt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_ro  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_last_ro <= bus.ro_in;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push_ok) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            r_mem[r_wr_ptr] <= bus.ro_in;
        end
    end

    assign bus.tx       = r_tx;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ro_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ro_uart_tx                                                      |
// | Directed self-checking bench for ro_uart_tx (N=8, DEPTH=4, CPB=4)  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_ro_uart_tx;
    localparam int N   = 8;
    localparam int DEP = 4;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   peak  = 0;
    logic [7:0] drive_q[$];

    ro_uart_tx_if #(.N(N), .DEPTH(DEP)) bus ();

    ro_uart_tx #(.N(N), .DEPTH(DEP), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then apply the next queued ro_in value.
    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(bus.level) > peak) peak = int'(bus.level);
        if (drive_q.size() != 0) bus.ro_in = drive_q.pop_front();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.ro_in = 8'h00;
        tick();
        tick();
        reset     = 1'b0;
    endtask

    // Called right after the edge that starts the frame; consumes 40 cycles.
    task automatic check_frame(input logic [7:0] b, input string tag);
        int   k;
        logic e;
        for (int i = 0; i < 10 * CPB; i++) begin
            k = i / CPB;
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = b[k-1];
            chk($sformatf("%s tx cyc%0d", tag, i), {31'd0, bus.tx}, {31'd0, e});
            tick();
        end
    endtask

    task automatic quiet_window(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.busy || bus.level != 0) seen = 1'b1;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.ro_in = 8'h00;

        // Reset state, then a held zero must not push
        do_reset();
        chk("rst tx",   {31'd0, bus.tx},       32'd1);
        chk("rst busy", {31'd0, bus.busy},     32'd0);
        chk("rst level", {29'd0, bus.level},   32'd0);
        chk("rst ovf",  {31'd0, bus.overflow}, 32'd0);
        quiet_window(20, "zero hold no push");

        // Single byte 0xA5
        bus.ro_in = 8'hA5;
        tick();
        chk("single E0 level", {29'd0, bus.level}, 32'd1);
        chk("single E0 tx",    {31'd0, bus.tx},    32'd1);
        chk("single E0 busy",  {31'd0, bus.busy},  32'd0);
        tick();
        chk("single E1 level", {29'd0, bus.level}, 32'd0);
        chk("single E1 busy",  {31'd0, bus.busy},  32'd1);
        check_frame(8'hA5, "single");
        chk("single end busy", {31'd0, bus.busy}, 32'd0);
        chk("single end tx",   {31'd0, bus.tx},   32'd1);

        // Back-to-back: 0x01, 0x02, 0x03 on consecutive cycles
        peak      = 0;
        bus.ro_in = 8'h01;
        drive_q   = '{8'h02, 8'h03};
        tick();
        tick();
        check_frame(8'h01, "b2b0");
        check_frame(8'h02, "b2b1");
        check_frame(8'h03, "b2b2");
        chk("b2b peak level", peak, 32'd2);
        chk("b2b end busy", {31'd0, bus.busy}, 32'd0);
        chk("b2b ovf",      {31'd0, bus.overflow}, 32'd0);

        // Overflow: six changes back-to-back, the sixth is dropped
        bus.ro_in = 8'h10;
        drive_q   = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        tick();
        tick();
        check_frame(8'h10, "ovf0");
        chk("ovf flag set", {31'd0, bus.overflow}, 32'd1);
        chk("ovf level",    {29'd0, bus.level},    32'd3);
        check_frame(8'h11, "ovf1");
        check_frame(8'h12, "ovf2");
        check_frame(8'h13, "ovf3");
        check_frame(8'h14, "ovf4");
        chk("ovf end busy", {31'd0, bus.busy}, 32'd0);
        quiet_window(20, "ovf no sixth frame");
        chk("ovf sticky", {31'd0, bus.overflow}, 32'd1);

        do_reset();
        chk("ovf cleared", {31'd0, bus.overflow}, 32'd0);

        // Duplicates: 0x07 held, then re-driven with the same value
        bus.ro_in = 8'h07;
        tick();
        tick();
        check_frame(8'h07, "dup");
        for (int i = 0; i < 8; i++) tick();
        bus.ro_in = 8'h07;
        quiet_window(30, "dup single frame");

        // Mid-frame reset during data bit 3 of 0xFF with two entries queued
        bus.ro_in = 8'hFF;
        drive_q   = '{8'h33, 8'h44};
        tick();
        tick();
        chk("mid start tx", {31'd0, bus.tx}, 32'd0);
        for (int i = 0; i < 17; i++) tick();
        chk("mid bit3 tx",    {31'd0, bus.tx},    32'd1);
        chk("mid bit3 level", {29'd0, bus.level}, 32'd2);
        reset     = 1'b1;
        bus.ro_in = 8'h00;
        tick();
        reset     = 1'b0;
        chk("mid rst tx",    {31'd0, bus.tx},    32'd1);
        chk("mid rst level", {29'd0, bus.level}, 32'd0);
        chk("mid rst busy",  {31'd0, bus.busy},  32'd0);
        quiet_window(50, "mid rst no frames");

        // Fresh change after the reset is serviced normally
        bus.ro_in = 8'h5A;
        tick();
        tick();
        check_frame(8'h5A, "post");
        chk("post end busy", {31'd0, bus.busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ro_uart_tx.md
# ro_uart_tx

Downstream output stage for the K2 8-bit core. It watches the core's `RO` output register and captures every value change into a small FIFO. It then serialises each captured byte as an 8N1 UART frame on a single `tx` line, so program output can be observed off-chip or in a bench without probing `RO` every cycle. It sits beside `K2` at the top level, fed directly by `K2.RO`.

## Interface
- `N`, default 8: data width; must match the K2 `RO` width.
- `DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit; must be at least 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; evaluated only on the rising edge of `clk`.
- `ro_in`  in  N: connected to `K2.RO`.
- `tx`  out  1: UART serial line; idle high.
- `busy`  out  1: high while a frame is being transmitted (state ≠ IDLE).
- `level`  out  $clog2(DEPTH+1): number of FIFO entries currently held.
- `overflow`  out  1: sticky; set when a change is dropped because the FIFO is full.

## Operation
- Reset values: `tx`=1, `busy`=0, `level`=0, `overflow`=0, state=IDLE, FIFO pointers=0, last-value register `last_ro`=0, bit counter=0, baud counter=0.
- Capture: on each edge where `ro_in != last_ro`:
  - `last_ro` takes `ro_in`.
  - A push is requested.
  - Repeated equal values never push.
  - After reset, the first nonzero `ro_in` pushes; a zero `ro_in` does not.
- Push: writes the new value at the write pointer if the FIFO is not full (pre-edge `level`, adjusted by a same-edge pop).
  - If the push is dropped, `overflow` is set and stays set until `reset`.
  - `last_ro` still updates on a dropped push.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `level` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- Pop: occurs when the FSM loads a byte. The popped value is the oldest entry (FIFO order).
- FSM states:
  - IDLE: `tx`=1. If pre-edge `level`>0, pop into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then the shift register shifts right. After bit N−1, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if `level`>0, pop and go directly to START (back-to-back frames); otherwise go to IDLE.
- The `tx` output is registered; it is driven from state and shift register flops, never combinationally from `ro_in`.
- Full with simultaneous pop: the push is accepted and no overflow occurs.
- Empty with simultaneous push: the pop decision uses pre-edge `level`=0, so nothing is popped. The byte is popped on the following edge.
- `reset` asserted mid-frame: on that edge all state returns to reset values, `tx` goes to 1 immediately, and FIFO contents are discarded.

## Timing
- Change-to-start latency from an idle, empty block:
  - Edge E0: `ro_in` differs from `last_ro`; push; `level`=1.
  - Edge E1: pop; state=START; `tx`=0 after E1; `level`=0.
- Frame length is exactly 10×CLKS_PER_BIT cycles: start, 8 data bits, stop.
- Back-to-back frames have no idle gap: the next start bit begins on the edge after the last stop-bit cycle.
- `busy` is high from E1 through the last stop-bit cycle, and low in IDLE.
- `ro_in` can change at most once per cycle; with CLKS_PER_BIT=4 the sustainable rate is one change per 40 cycles. Bursts of up to DEPTH+1 changes during one frame are lossless.

## Test plan
- Reset check: assert `reset` for 2 edges with `ro_in`=0x00 → `tx`=1, `busy`=0, `level`=0, `overflow`=0; holding 0x00 for 20 cycles gives no push.
- Single byte: `ro_in`=0xA5 held, CLKS_PER_BIT=4 → start bit on the second edge; `tx` sequence is 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles; `busy` low after 40 cycles.
- Back-to-back: `ro_in` 0x01, then 0x02 and 0x03 on consecutive cycles → three frames with no idle gap, in order 0x01, 0x02, 0x03; `level` peaks at 2.
- Overflow: 6 distinct values on consecutive cycles with DEPTH=4 → first popped to the shift register, next 4 stored, sixth dropped; `overflow`=1 and stays 1; 5 frames transmitted.
- Duplicates: `ro_in` 0x07 held 50 cycles, then 0x07 again → exactly one frame.
- Mid-frame reset: `reset` during DATA bit 3 of 0xFF with 2 entries queued → `tx`=1, `level`=0, `busy`=0 on the next cycle; no further frames until a new change.
